// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a FIFO with registered read data.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | half-bit wait, then confirm the start bit
// DATA   | sample 8 data bits, LSB first
// PARITY | sample the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample the stop bit, then push the byte or flag an error
// BREAK  | line held low after a framing error, wait for high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        serial_i,
    input  logic                        rden_i,
    output logic [7:0]                  byte_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        frame_err_o,
    output logic                        overflow_o,
    output logic                        parity_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic          sync1_q, sync2_q, rx;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req, push_ok, pop, frame_err;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    byte_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d, par_err;
`endif

    assign rx = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= serial_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) par_bad_q <= 1'b0;
        else       par_bad_q <= par_bad_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_err   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                bit_d = '0;
                if (!rx) begin
                    state_d = S_START;
                    tmr_d   = TMR_HALF;
                end
            end
            S_START: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (!rx) begin
                    state_d = S_DATA;
                    tmr_d   = TMR_FULL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else begin
                    shift_d = {rx, shift_q[7:1]};
                    tmr_d   = TMR_FULL;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else begin
                    par_bad_d = rx != (^shift_q);
                    tmr_d     = TMR_FULL;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (rx) begin
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    par_err  = par_bad_q;
                    push_req = !par_bad_q;
`else
                    push_req = 1'b1;
`endif
                end else begin
                    frame_err = 1'b1;
                    state_d   = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO can still take a byte when a pop frees a slot in the same cycle.
    assign pop     = rden_i && !empty_o;
    assign push_ok = push_req && (!full_o || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            byte_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                byte_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign byte_o      = byte_q;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == DEPTH_C);
    assign frame_err_o = frame_err;
    assign overflow_o  = push_req && full_o && !pop;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = par_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo against a queue-based model of received bytes.
module tb_uart_rx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i, serial_i, rden_i;
    logic [7:0] byte_o;
    logic       empty_o, full_o, frame_err_o, overflow_o, parity_err_o;
    logic [4:0] count_o;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .serial_i(serial_i), .rden_i(rden_i),
        .byte_o(byte_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
        .frame_err_o(frame_err_o), .overflow_o(overflow_o), .parity_err_o(parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] q[$];
    logic [7:0] last_byte;
    int exp_ferr, exp_ovf, exp_perr;
    int ferr_seen, ovf_seen, perr_seen;
    int n_checks, n_errors;

    always @(negedge clk_i) begin
        if (frame_err_o)  ferr_seen++;
        if (overflow_o)   ovf_seen++;
        if (parity_err_o) perr_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        serial_i = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    // Returns on the negedge just before the stop-sample edge (or one cycle
    // later when a pop is issued on that edge).
    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit par_flip,
                              input bit pop_at_stop);
        bit good;
        serial_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            serial_i = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        if (PARITY_ON) begin
            serial_i = (^b) ^ par_flip;
            repeat (CPB) @(negedge clk_i);
        end
        if (stop_low > 0) begin
            serial_i = 1'b0;
            repeat (stop_low) @(negedge clk_i);
            serial_i = 1'b1;
            exp_ferr++;
        end else begin
            serial_i = 1'b1;
            repeat (CPB) @(negedge clk_i);
            good = !(PARITY_ON && par_flip);
            if (pop_at_stop) begin
                rden_i = 1'b1;
                @(negedge clk_i);
                rden_i = 1'b0;
            end
            if (pop_at_stop && q.size() > 0) last_byte = q.pop_front();
            if (!good)                 exp_perr++;
            else if (q.size() >= DEPTH) exp_ovf++;
            else                       q.push_back(b);
            if (pop_at_stop) begin
                check("pop_at_stop byte", 32'(byte_o), 32'(last_byte));
                check("pop_at_stop count", 32'(count_o), 32'(q.size()));
            end
        end
    endtask

    task automatic pop_check();
        rden_i = 1'b1;
        @(negedge clk_i);
        rden_i = 1'b0;
        if (q.size() > 0) last_byte = q.pop_front();
        check("pop byte", 32'(byte_o), 32'(last_byte));
        check("pop count", 32'(count_o), 32'(q.size()));
        check("pop empty", 32'(empty_o), 32'(q.size() == 0));
    endtask

    initial begin
        int r;
        rst_i = 1'b1; serial_i = 1'b1; rden_i = 1'b0;
        last_byte = 8'h00;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst byte", 32'(byte_o), 32'h0);
        check("rst empty", 32'(empty_o), 32'h1);
        check("rst full", 32'(full_o), 32'h0);
        check("rst count", 32'(count_o), 32'h0);
        check("rst pulses", 32'({frame_err_o, overflow_o, parity_err_o}), 32'h0);
        idle(4);

        // 0x55: empty_o falls one cycle after the stop sample
        send_frame(8'h55, 0, 1'b0, 1'b0);
        check("empty before push", 32'(empty_o), 32'h1);
        @(negedge clk_i);
        check("empty after push", 32'(empty_o), 32'h0);
        check("count after push", 32'(count_o), 32'h1);
        pop_check();

        // 1-cycle glitch is rejected silently
        serial_i = 1'b0;
        @(negedge clk_i);
        idle(10);
        check("glitch count", 32'(count_o), 32'h0);
        check("glitch ferr", 32'(ferr_seen), 32'(exp_ferr));

        // break: stop held low for 20 cycles
        send_frame(8'hA3, 20, 1'b0, 1'b0);
        idle(6);
        check("break ferr", 32'(ferr_seen), 32'(exp_ferr));
        check("break count", 32'(count_o), 32'h0);
        send_frame(8'h5A, 0, 1'b0, 1'b0);
        idle(3);
        pop_check();

        // fill to full, then overflow
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 0, 1'b0, 1'b0);
            if (i == 15) begin
                idle(2);
                check("full after 16", 32'(full_o), 32'h1);
                check("count after 16", 32'(count_o), 32'd16);
            end
        end
        idle(3);
        check("overflow pulses", 32'(ovf_seen), 32'(exp_ovf));
        check("count after 17", 32'(count_o), 32'd16);
        // push and pop on the same edge while full
        send_frame(8'hC4, 0, 1'b0, 1'b1);
        idle(2);
        check("no ovf on push+pop", 32'(ovf_seen), 32'(exp_ovf));
        while (q.size() > 0) pop_check();
        pop_check();
        // push and pop on the same edge while empty
        send_frame(8'h99, 0, 1'b0, 1'b1);
        idle(2);

        // reset in the middle of 0xFF
        serial_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        serial_i = 1'b1;
        repeat (3 * CPB) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        last_byte = 8'h00;
        check("midrst count", 32'(count_o), 32'h0);
        check("midrst byte", 32'(byte_o), 32'h0);
        idle(30);
        check("midrst no push", 32'(count_o), 32'h0);
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        idle(3);
        pop_check();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1'b1, 1'b0);
        idle(3);
        check("parity err pulses", 32'(perr_seen), 32'(exp_perr));
        check("parity no push", 32'(count_o), 32'(q.size()));
        send_frame(8'h07, 0, 1'b0, 1'b0);
        idle(3);
        pop_check();
`endif

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                send_frame(8'($urandom), 0, 1'b0, ($urandom_range(0, 3) == 0));
                idle($urandom_range(1, 3));
            end else if (r == 5) begin
                send_frame(8'($urandom), $urandom_range(4, 12), 1'b0, 1'b0);
                idle(5);
            end else if (r == 6) begin
                serial_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk_i);
                idle(10);
            end else if (r <= 8) begin
                repeat ($urandom_range(1, 4)) pop_check();
            end else begin
                send_frame(8'($urandom), 0, 1'b1, 1'b0);
                idle(2);
            end
        end
        idle(4);
        check("rand count", 32'(count_o), 32'(q.size()));
        while (q.size() > 0) pop_check();
        pop_check();
        idle(4);
        check("total ferr", 32'(ferr_seen), 32'(exp_ferr));
        check("total ovf", 32'(ovf_seen), 32'(exp_ovf));
        check("total perr", 32'(perr_seen), 32'(exp_perr));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
